// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios/ReCOP input PIO: register map, edge encodings, bus word type.
package nios_pio_pkg;

    localparam int unsigned PIO_BUS_W = 32;

    typedef logic [PIO_BUS_W-1:0] pio_word_t;

    // Word addresses of the slave registers
    localparam logic [1:0] PIO_A_DATA = 2'd0;
    localparam logic [1:0] PIO_A_MASK = 2'd1;
    localparam logic [1:0] PIO_A_EDGE = 2'd2;
    localparam logic [1:0] PIO_A_SNAP = 2'd3;

    // Edge selection encodings for EDGE_TYPE
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// Single-bit debounce filter: q follows d only after d has differed from q for
// DEB_CYCLES consecutive clocks. Only compiled when PIO_DEBOUNCE_EN is defined.
`ifdef PIO_DEBOUNCE_EN
module pio_debounce_bit #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_q;

    // Count consecutive disagreements; any agreement restarts the count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_q   <= 1'b0;
        end else if (d == r_q) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
            r_cnt <= '0;
            r_q   <= d;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign q = r_q;

endmodule
`endif

// File: rtl/nios_pio_in_edge.sv
// Avalon-MM input PIO: synchronises in_port, captures selected edges into sticky
// bits and raises a maskable level irq. Optional per-bit debounce: PIO_DEBOUNCE_EN.
module nios_pio_in_edge
    import nios_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned IRQ_RESET   = 0,
    parameter int unsigned DEB_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] w_cap_next;
    logic [WIDTH-1:0] r_snap;
    pio_word_t        r_rdata;
    logic             r_irq;
    logic             w_wr;

    // Synchroniser chain for the asynchronous inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
    // Per-bit debounce filters produce the filtered value
    for (genvar g = 0; g < WIDTH; g++) begin : g_deb
        pio_debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (w_sync[g]),
            .q       (w_filt[g])
        );
    end
`else
    logic [WIDTH-1:0] r_filt;

    // Filtered value is the synchronised value, one flop later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_filt <= '0;
        else          r_filt <= w_sync;
    end

    assign w_filt = r_filt;
`endif

    // Previous filtered value for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_prev <= '0;
        else          r_prev <= w_filt;
    end

    // Edge selection and next capture value (edge wins over a same-clock clear)
    always_comb begin
        w_edge = w_filt & ~r_prev;
        if (EDGE_TYPE == EDGE_FALL)     w_edge = ~w_filt & r_prev;
        else if (EDGE_TYPE == EDGE_ANY) w_edge = w_filt ^ r_prev;
        w_wr       = chipselect & ~write_n;
        w_cap_next = r_cap;
        if (w_wr && (address == PIO_A_EDGE)) w_cap_next = r_cap & ~writedata[WIDTH-1:0];
        w_cap_next = w_cap_next | w_edge;
    end

    // Writable registers: mask, sticky capture, snapshot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= WIDTH'(IRQ_RESET);
            r_cap  <= '0;
            r_snap <= '0;
        end else begin
            r_cap <= w_cap_next;
            if (w_wr && (address == PIO_A_MASK)) r_mask <= writedata[WIDTH-1:0];
            if (w_wr && (address == PIO_A_SNAP)) r_snap <= w_filt;
        end
    end

    // Registered read mux and level interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            case (address)
                PIO_A_DATA: r_rdata <= PIO_BUS_W'(w_filt);
                PIO_A_MASK: r_rdata <= PIO_BUS_W'(r_mask);
                PIO_A_EDGE: r_rdata <= PIO_BUS_W'(r_cap);
                default:    r_rdata <= PIO_BUS_W'(r_snap);
            endcase
            r_irq <= |(w_cap_next & r_mask);
        end
    end

    assign readdata = r_rdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_nios_pio_in_edge.sv
// Directed self-checking bench for nios_pio_in_edge (WIDTH 8, SYNC_STAGES 2, rising edges).
module tb_nios_pio_in_edge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int vectors = 0;
    int errors  = 0;

    nios_pio_in_edge #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .EDGE_TYPE   (0),
        .IRQ_RESET   (32'h3C),
        .DEB_CYCLES  (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, input string tag, input logic [31:0] exp);
        address = a;
        tick();
        check(tag, readdata, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'hFF;
        tick(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        bus_read(2'd1, "mask_reset_value", 32'h3C);

`ifndef PIO_DEBOUNCE_EN
        // High input at reset becomes rising edges once filtered
        tick(4);
        check("post_reset_irq", {31'h0, irq}, 32'h1);
        bus_read(2'd2, "post_reset_cap", 32'hFF);
        bus_read(2'd0, "post_reset_data", 32'hFF);
        bus_write(2'd2, 32'hFF);
        check("clear_all_irq", {31'h0, irq}, 32'h0);
        bus_read(2'd2, "clear_all_cap", 32'h0);

        // Data path latency: SYNC_STAGES+2 clocks
        in_port = 8'h00;
        address = 2'd0;
        tick(5);
        check("data_zero", readdata, 32'h0);
        in_port = 8'hA5;
        tick(3);
        check("data_lat_minus1", readdata, 32'h0);
        tick();
        check("data_lat_exact", readdata, 32'h000000A5);
        bus_read(2'd2, "data_cap", 32'hA5);
        in_port = 8'h00;
        tick(5);
        bus_write(2'd2, 32'hFF);
        bus_read(2'd2, "falling_not_captured", 32'h0);

        // Single rising edge with mask 0x01
        bus_write(2'd1, 32'h01);
        in_port = 8'h01;
        tick(3);
        check("edge_irq_early", {31'h0, irq}, 32'h0);
        tick();
        check("edge_irq_set", {31'h0, irq}, 32'h1);
        bus_read(2'd2, "edge_cap_set", 32'h01);
        bus_read(2'd2, "edge_cap_sticky", 32'h01);
        bus_write(2'd2, 32'h01);
        check("edge_irq_clear", {31'h0, irq}, 32'h0);
        bus_read(2'd2, "edge_cap_clear", 32'h0);
        in_port = 8'h00;
        tick(5);
        bus_write(2'd2, 32'hFF);

        // Edge on bit3 on the same clock as its W1C
        bus_write(2'd1, 32'h08);
        in_port = 8'h08;
        tick(3);
        bus_write(2'd2, 32'h08);
        check("collide_irq", {31'h0, irq}, 32'h1);
        bus_read(2'd2, "collide_cap", 32'h08);
        bus_write(2'd2, 32'h08);
        check("collide_clear_irq", {31'h0, irq}, 32'h0);
        bus_read(2'd2, "collide_clear_cap", 32'h0);
        in_port = 8'h00;
        tick(5);
        bus_write(2'd2, 32'hFF);

        // Masked edges, then unmask
        bus_write(2'd1, 32'h0F);
        in_port = 8'hF0;
        tick(6);
        check("masked_irq", {31'h0, irq}, 32'h0);
        bus_read(2'd2, "masked_cap", 32'hF0);
        bus_write(2'd1, 32'hFF);
        check("unmask_irq_same", {31'h0, irq}, 32'h0);
        tick();
        check("unmask_irq_next", {31'h0, irq}, 32'h1);
        bus_read(2'd1, "mask_readback", 32'hFF);

        // Snapshot and read-only DATA
        in_port = 8'h3C;
        tick(5);
        bus_write(2'd3, 32'h0);
        in_port = 8'h00;
        bus_read(2'd3, "snapshot", 32'h3C);
        tick(5);
        bus_write(2'd0, 32'hFF);
        bus_read(2'd0, "data_read_only", 32'h0);
`else
        // Debounced path: settle, clear, then glitch and hold on bit0
        in_port = 8'h00;
        tick(60);
        bus_write(2'd2, 32'hFF);
        bus_read(2'd0, "deb_settle_data", 32'h0);
        bus_read(2'd2, "deb_settle_cap", 32'h0);
        bus_write(2'd1, 32'h01);
        in_port = 8'h01;
        tick(10);
        in_port = 8'h00;
        address = 2'd0;
        for (int k = 0; k < 30; k++) begin
            tick();
            check("deb_glitch_data", readdata, 32'h0);
        end
        bus_read(2'd2, "deb_glitch_cap", 32'h0);
        check("deb_glitch_irq", {31'h0, irq}, 32'h0);
        in_port = 8'h01;
        tick(20);
        bus_read(2'd0, "deb_hold_data", 32'h01);
        bus_read(2'd2, "deb_hold_cap", 32'h01);
        check("deb_hold_irq", {31'h0, irq}, 32'h1);
`endif

        // Asynchronous reset mid-operation
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_readdata", readdata, 32'h0);
        check("async_reset_irq", {31'h0, irq}, 32'h0);
        tick(2);
        reset_n = 1'b1;
        bus_read(2'd2, "async_reset_cap", 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
